// File: rtl/decode_stage.sv
// Instruction decode stage: a small FIFO of raw instruction words.
// The outputs show the fields of the oldest word, zeroed while the buffer is empty.
module decode_stage #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 5,
  parameter int IMM_W   = 16,
  parameter int XIMM_W  = 32,
  parameter int JMP_W   = 26,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         instruction,
  input  logic                       imm_signed,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPC_W-1:0]           opcode,
  output logic [REG_W-1:0]           rs,
  output logic [REG_W-1:0]           rt,
  output logic [REG_W-1:0]           rd,
  output logic [XIMM_W-1:0]          imm,
  output logic [JMP_W-1:0]           jump_addr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic               r_sgn [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_accept;
  logic               w_pop;
  logic [INSTR_W-1:0] w_head;
  logic               w_head_sgn;
  logic [IMM_W-1:0]   w_raw_imm;
  logic [XIMM_W-1:0]  w_ext_imm;

  // Both flags come only from registered count, so input never reaches output in one cycle.
  assign in_ready  = (r_count < CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_accept = in_valid && in_ready && !flush;
  assign w_pop    = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left uncleared on reset; the zeroed count hides stale entries.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= instruction;
      r_sgn[r_wr_ptr] <= imm_signed;
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_sgn = r_sgn[r_rd_ptr];
  assign w_raw_imm  = w_head[IMM_W-1:0];
  assign w_ext_imm  = w_head_sgn ? XIMM_W'($signed(w_raw_imm)) : XIMM_W'(w_raw_imm);

  assign opcode    = out_valid ? w_head[INSTR_W-1 -: OPC_W] : '0;
  assign rs        = out_valid ? w_head[INSTR_W-OPC_W-1 -: REG_W] : '0;
  assign rt        = out_valid ? w_head[INSTR_W-OPC_W-REG_W-1 -: REG_W] : '0;
  assign rd        = out_valid ? w_head[INSTR_W-OPC_W-2*REG_W-1 -: REG_W] : '0;
  assign imm       = out_valid ? w_ext_imm : '0;
  assign jump_addr = out_valid ? w_head[JMP_W-1:0] : '0;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter INSTR_W, default 32: instruction width in bits.
REQ-002 Parameter OPC_W, default 4: opcode field width.
REQ-003 Parameter REG_W, default 5: width of each register-specifier field (rs, rt, rd).
REQ-004 Parameter IMM_W, default 16: raw immediate width.
REQ-005 Parameter XIMM_W, default 32: extended immediate width; XIMM_W >= IMM_W.
REQ-006 Parameter JMP_W, default 26: jump-address width; JMP_W <= INSTR_W-OPC_W.
REQ-007 Parameter DEPTH, default 2: buffer entries; power of two, >= 2.
REQ-008 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-009 Port clk, input, 1: clock; all state changes on its rising edge.
REQ-010 Port rst, input, 1: asynchronous active-high reset.
REQ-011 Port in_valid, input, 1: upstream instruction valid.
REQ-012 Port in_ready, output, 1: buffer can accept.
REQ-013 Port instruction, input, INSTR_W: raw instruction word.
REQ-014 Port imm_signed, input, 1: 1 = sign-extend immediate, 0 = zero-extend; sampled with the instruction.
REQ-015 Port flush, input, 1: discard all buffered instructions.
REQ-016 Port out_valid, output, 1: decoded fields valid.
REQ-017 Port out_ready, input, 1: downstream accepts.
REQ-018 Ports opcode (OPC_W), rs, rt, rd (REG_W each), imm (XIMM_W), jump_addr (JMP_W), outputs: decoded fields of buffer head.
REQ-019 Port count, output, $clog2(DEPTH)+1: number of buffered entries.

Function
REQ-020 Accept occurs when in_valid && in_ready && !flush; the instruction and imm_signed are written to the buffer tail.
REQ-021 Pop occurs when out_valid && out_ready && !flush; head advances.
REQ-022 in_ready SHALL equal (count < DEPTH); no bypass when full, even if a pop occurs in the same cycle.
REQ-023 out_valid SHALL equal (count != 0).
REQ-024 Latency: an instruction accepted at edge N is presented on the outputs after edge N if the buffer was empty; the buffer never forwards combinationally from input to output.
REQ-025 Simultaneous accept and pop SHALL leave count unchanged and preserve FIFO order.
REQ-026 Field extraction from the head word: opcode = [INSTR_W-1 -: OPC_W]; rs = next REG_W bits below; rt = next REG_W below rs; rd = next REG_W below rt; raw imm = [IMM_W-1:0]; jump_addr = [JMP_W-1:0].
REQ-027 imm SHALL equal raw imm sign-extended to XIMM_W if the stored imm_signed = 1, else zero-extended.
REQ-028 While out_valid = 0, all decoded outputs SHALL be driven to 0.
REQ-029 Read and write pointers wrap modulo DEPTH; count saturates at neither bound, since accept at full and pop at empty are impossible.
REQ-030 Flush takes priority: on the flush edge the pointers and count return to 0 and any same-cycle accept or pop is ignored.

Reset
REQ-031 While rst = 1, the following SHALL hold asynchronously: count = 0, pointers = 0, out_valid = 0, all decoded outputs = 0, in_ready = 1.
REQ-032 Reset asserted mid-stream SHALL discard all entries; buffer contents need no clearing.

Verification
REQ-033 Accept 0x12345678 with imm_signed=1 into the empty buffer -> next cycle: out_valid=1, opcode=1, rs=4, rt=13, rd=2, imm=0x00005678, jump_addr=0x2345678.
REQ-034 Accept 0x00008001 with imm_signed=1, then with imm_signed=0; hold out_ready=0 -> count=2, in_ready=0; then pop -> imm=0xFFFF8001, then imm=0x00008001.
REQ-035 With the buffer full, assert in_valid and out_ready together -> one pop, no accept, count=1, in_ready=1 in the next cycle.
REQ-036 Stream 8 words with in_valid=out_ready=1 -> words emerge in order, pointers wrap, count stays at 1 in steady state.
REQ-037 With count=2, assert flush together with in_valid -> next cycle count=0, out_valid=0, all fields 0, incoming word dropped.
REQ-038 Assert rst between clock edges with count=1 -> out_valid falls immediately, without waiting for a clock edge; after release, in_ready=1.
